// File: rtl/edge_detector_multi.sv
// Multi-channel synchronising edge detector with sticky rise/fall status and irq.
// Optional per-channel debounce filter compiled in with EDGE_DET_DEBOUNCE_EN.
module edge_detector_multi #(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic [WIDTH-1:0] rise_mask,
   input  logic [WIDTH-1:0] fall_mask,
   input  logic [WIDTH-1:0] clr,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rising_edge,
   output logic [WIDTH-1:0] falling_edge,
   output logic [WIDTH-1:0] rise_sticky,
   output logic [WIDTH-1:0] fall_sticky,
   output logic             irq
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
   logic [WIDTH-1:0]                  sync_out_s;
   logic [WIDTH-1:0]                  prev_r;

   assign sync_out_s = sync_r[SYNC_STAGES-1];

   // Synchroniser chain; stage 0 samples the asynchronous inputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_r <= '0;
      end else begin
         sync_r[0] <= din;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_r[s] <= sync_r[s-1];
         end
      end
   end

`ifdef EDGE_DET_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic [CNT_W-1:0] cnt_r [WIDTH];

   // Level follows the synchroniser only after DEBOUNCE_CYCLES consecutive disagreeing clocks.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync_out_s[i] == level[i]) begin
               cnt_r[i] <= '0;
            end else if (cnt_r[i] == CNT_MAX) begin
               level[i] <= sync_out_s[i];
               cnt_r[i] <= '0;
            end else begin
               cnt_r[i] <= cnt_r[i] + CNT_W'(1);
            end
         end
      end
   end
`else
   // Level is the registered synchroniser output.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level <= '0;
      end else begin
         level <= sync_out_s;
      end
   end
`endif

   // Edge pulses compare level against its one-cycle-old copy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_r       <= '0;
         rising_edge  <= '0;
         falling_edge <= '0;
      end else begin
         prev_r       <= level;
         rising_edge  <= level & ~prev_r;
         falling_edge <= ~level & prev_r;
      end
   end

   // Sticky status: a new masked edge wins over a simultaneous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rise_sticky <= '0;
         fall_sticky <= '0;
      end else begin
         rise_sticky <= (rise_sticky & ~clr) | (rising_edge & rise_mask);
         fall_sticky <= (fall_sticky & ~clr) | (falling_edge & fall_mask);
      end
   end

   assign irq = |{rise_sticky, fall_sticky};

endmodule

// File: tb/tb_edge_detector_multi.sv
// Directed testbench for edge_detector_multi (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_edge_detector_multi;

   localparam int W = 4;
`ifdef EDGE_DET_DEBOUNCE_EN
   localparam int DB = 4;
`else
   localparam int DB = 0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] din, rise_mask, fall_mask, clr;
   logic [W-1:0] level, rising_edge, falling_edge, rise_sticky, fall_sticky;
   logic         irq;
   logic [W-1:0] seen;

   int checks_r   = 0;
   int failures_r = 0;

   edge_detector_multi #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .din(din), .rise_mask(rise_mask), .fall_mask(fall_mask),
      .clr(clr), .level(level), .rising_edge(rising_edge), .falling_edge(falling_edge),
      .rise_sticky(rise_sticky), .fall_sticky(fall_sticky), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks_r++;
      if (got !== exp) begin
         failures_r++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      reset = 1'b0; din = 4'b0000; rise_mask = 4'b1111; fall_mask = 4'b1111; clr = 4'b0000;
      #1;
      check("rst_level", level, 4'b0000);
      check("rst_rise", rising_edge, 4'b0000);
      check("rst_fall", falling_edge, 4'b0000);
      check("rst_rsticky", rise_sticky, 4'b0000);
      check("rst_fsticky", fall_sticky, 4'b0000);
      check("rst_irq", {3'b000, irq}, 4'b0000);
      tick_n(2);
      reset = 1'b1;
      tick_n(3);

      // Single rising edge: latency and one-cycle pulse
      din = 4'b0001;
      tick_n(2 + DB);
      check("lat_level_early", level, 4'b0000);
      tick();
      check("lat_level", level, 4'b0001);
      check("lat_rise_early", rising_edge, 4'b0000);
      tick();
      check("pulse_rise", rising_edge, 4'b0001);
      check("pulse_nofall", falling_edge, 4'b0000);
      check("sticky_early", rise_sticky, 4'b0000);
      tick();
      check("pulse_end", rising_edge, 4'b0000);
      check("rsticky_set", rise_sticky, 4'b0001);
      check("irq_set", {3'b000, irq}, 4'b0001);
      tick_n(3);
      check("held_no_pulse", rising_edge, 4'b0000);

      // All channels fall together, fall mask 0101
      din = 4'b1111;
      tick_n(8 + DB);
      check("rsticky_all", rise_sticky, 4'b1111);
      fall_mask = 4'b0101;
      din = 4'b0000;
      tick_n(4 + DB);
      check("fall_all", falling_edge, 4'b1111);
      check("fall_norise", rising_edge, 4'b0000);
      tick();
      check("fall_end", falling_edge, 4'b0000);
      check("fsticky_mask", fall_sticky, 4'b0101);
      check("rsticky_kept", rise_sticky, 4'b1111);

      clr = 4'b1111;
      tick();
      clr = 4'b0000;
      check("clr_rs", rise_sticky, 4'b0000);
      check("clr_fs", fall_sticky, 4'b0000);
      check("clr_irq", {3'b000, irq}, 4'b0000);

      // Set wins over simultaneous clear, later clear takes effect
      din = 4'b0001;
      tick_n(4 + DB);
      check("p3_rise", rising_edge, 4'b0001);
      clr = 4'b0001;
      tick();
      check("set_wins", rise_sticky, 4'b0001);
      tick();
      check("clr_later", rise_sticky, 4'b0000);
      check("clr_later_irq", {3'b000, irq}, 4'b0000);
      clr = 4'b0000;

      // Masks gate sticky capture only
      rise_mask = 4'b0000;
      din = 4'b0011;
      tick_n(4 + DB);
      check("mask_pulse", rising_edge, 4'b0010);
      tick();
      check("mask_nosticky", rise_sticky, 4'b0000);
      check("mask_level", level, 4'b0011);
      rise_mask = 4'b1111;
      din = 4'b0111;
      tick_n(5 + DB);
      check("mask_set", rise_sticky, 4'b0100);
      rise_mask = 4'b0000;
      tick_n(2);
      check("mask_clr_keeps", rise_sticky, 4'b0100);

`ifdef EDGE_DET_DEBOUNCE_EN
      // Glitch of 3 clocks is filtered; sustained high gives one pulse
      din = 4'b0101;
      tick_n(12);
      din = 4'b0111;
      tick_n(3);
      din = 4'b0101;
      seen = 4'b0000;
      for (int k = 0; k < 12; k++) begin
         tick();
         seen = seen | rising_edge | (level & 4'b0010);
      end
      check("db_glitch", seen, 4'b0000);
      din = 4'b0111;
      tick_n(3 + DB);
      check("db_early", rising_edge, 4'b0000);
      tick();
      check("db_pulse", rising_edge, 4'b0010);
`endif

      // Input held through reset, then reset mid-pulse
      din = 4'b1010;
      reset = 1'b0;
      #1;
      check("async_rst_level", level, 4'b0000);
      check("async_rst_rs", rise_sticky, 4'b0000);
      tick_n(3);
      reset = 1'b1;
      tick_n(3 + DB);
      check("rel_level", level, 4'b1010);
      check("rel_rise_early", rising_edge, 4'b0000);
      tick();
      check("rel_rise", rising_edge, 4'b1010);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rise", rising_edge, 4'b0000);
      check("mid_level", level, 4'b0000);
      check("mid_fall", falling_edge, 4'b0000);
      check("mid_irq", {3'b000, irq}, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", checks_r, failures_r);
      $finish;
   end

endmodule
